// File: rtl/flappy_pkg.sv
`default_nettype none
// ============================================================================
// Module      : flappy_pkg
// Description : Shared types and constants for the flappy game controller:
//               game state encoding, keycodes and default play-field geometry.
// Revision    : 1.0 - initial release
// ============================================================================
package flappy_pkg;

    // Game state as seen on the HUD port (encoding is externally visible)
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_DYING = 2'd2,
        S_OVER  = 2'd3
    } game_state_t;

    // USB keycodes
    localparam logic [7:0] FLAP_KEY  = 8'h1A;
    localparam logic [7:0] START_KEY = 8'h2C;

    // Play-field geometry defaults, in pixels
    localparam int PIPE_HALF_W  = 20;
    localparam int GAP_HALF     = 50;
    localparam int GROUND_Y     = 440;

    // Frames spent falling before the game-over screen
    localparam int DEATH_FRAMES = 30;

endpackage : flappy_pkg
`default_nettype wire

// File: rtl/bcd_score_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_score_counter
// Description : Two-digit BCD counter that increments by one on inc,
//               saturates at 99 and clears synchronously on clear.
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_score_counter (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;
    logic       w_at_max;

    assign w_at_max = (r_tens == 4'd9) && (r_ones == 4'd9);

    // Clear has priority; otherwise count up in BCD and hold at 99
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (clear) begin
            r_tens <= 4'd0;
            r_ones <= 4'd0;
        end else if (inc && !w_at_max) begin
            if (r_ones == 4'd9) begin
                r_ones <= 4'd0;
                r_tens <= r_tens + 4'd1;
            end else begin
                r_ones <= r_ones + 4'd1;
            end
        end
    end

    assign tens = r_tens;
    assign ones = r_ones;

endmodule : bcd_score_counter
`default_nettype wire

// File: rtl/flappy_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : flappy_game_ctrl
// Description : Per-frame game controller. Detects bird/pipe/ground/ceiling
//               collisions, counts passed pipes into a BCD score, turns
//               keycodes into one-frame press pulses and sequences the
//               IDLE/PLAY/DYING/OVER game states that gate motion.
// Revision    : 1.0 - initial release
// ============================================================================
module flappy_game_ctrl #(
    parameter int         PIPE_HALF_W  = flappy_pkg::PIPE_HALF_W,
    parameter int         GAP_HALF     = flappy_pkg::GAP_HALF,
    parameter int         GROUND_Y     = flappy_pkg::GROUND_Y,
    parameter logic [7:0] FLAP_KEY     = flappy_pkg::FLAP_KEY,
    parameter logic [7:0] START_KEY    = flappy_pkg::START_KEY,
    parameter int         DEATH_FRAMES = flappy_pkg::DEATH_FRAMES
) (
    input  logic       frame_clk,
    input  logic       Reset_n,
    input  logic [7:0] keycode,
    input  logic [9:0] BirdX,
    input  logic [9:0] BirdY,
    input  logic [9:0] BirdS,
    input  logic [9:0] Pipe0X,
    input  logic [9:0] Pipe1X,
    input  logic [9:0] Pipe2X,
    input  logic [9:0] Pipe0Y,
    input  logic [9:0] Pipe1Y,
    input  logic [9:0] Pipe2Y,
    output logic [1:0] game_state,
    output logic       run_pipes,
    output logic       run_bird,
    output logic       flap,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic       game_over
);

    import flappy_pkg::*;

    localparam int          c_num_pipes  = 3;
    localparam logic [10:0] c_half_w     = 11'(PIPE_HALF_W);
    localparam logic [10:0] c_gap_half   = 11'(GAP_HALF);
    localparam logic [10:0] c_ground_y   = 11'(GROUND_Y);
    localparam int          c_cnt_w      = (DEATH_FRAMES > 1) ? $clog2(DEATH_FRAMES) : 1;
    localparam logic [c_cnt_w-1:0] c_death_last = c_cnt_w'(DEATH_FRAMES - 1);

    // ------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------
    game_state_t                r_state;
    game_state_t                w_state_next;
    logic [c_cnt_w-1:0]         r_death_cnt;
    logic [c_cnt_w-1:0]         w_death_cnt_next;
    logic [7:0]                 r_key_prev;
    logic                       r_hit_q;
    logic [c_num_pipes-1:0]     r_passed;
    logic                       r_run_pipes;
    logic                       r_run_bird;
    logic                       r_game_over;
    logic                       r_flap;

    logic                       w_run_pipes_next;
    logic                       w_run_bird_next;
    logic                       w_game_over_next;
    logic                       w_flap_next;

    logic                       w_flap_press;
    logic                       w_start_press;
    logic [c_num_pipes-1:0]     w_pipe_hit;
    logic [c_num_pipes-1:0]     w_pass_new;
    logic [c_num_pipes-1:0]     w_passed_next;
    logic                       w_ground_hit;
    logic                       w_ceiling_hit;
    logic                       w_hit;
    logic                       w_score_inc;
    logic                       w_score_clear;

    // Geometry widened to 11 bits so sums of two 10-bit terms cannot wrap
    logic [10:0]                w_bx;
    logic [10:0]                w_by;
    logic [10:0]                w_bs;
    logic [c_num_pipes-1:0][9:0] w_pipe_x;
    logic [c_num_pipes-1:0][9:0] w_pipe_y;

    assign w_bx     = {1'b0, BirdX};
    assign w_by     = {1'b0, BirdY};
    assign w_bs     = {1'b0, BirdS};
    assign w_pipe_x = {Pipe2X, Pipe1X, Pipe0X};
    assign w_pipe_y = {Pipe2Y, Pipe1Y, Pipe0Y};

    // ------------------------------------------------------------------
    // Key press edges: a held key yields one press only
    // ------------------------------------------------------------------
    assign w_flap_press  = (keycode == FLAP_KEY)  && (r_key_prev != FLAP_KEY);
    assign w_start_press = (keycode == START_KEY) && (r_key_prev != START_KEY);

    // ------------------------------------------------------------------
    // Per-pipe collision and pass detection. Subtractions are rewritten
    // as additions on the other side so no operand goes negative.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < c_num_pipes; gi++) begin : g_pipe
            logic [10:0] w_px;
            logic [10:0] w_py;
            logic        w_overlap;
            logic        w_outside_gap;
            logic        w_pass_set;
            logic        w_pass_clr;

            assign w_px = {1'b0, w_pipe_x[gi]};
            assign w_py = {1'b0, w_pipe_y[gi]};

            assign w_overlap = (w_bx + w_bs + c_half_w >= w_px) &&
                               (w_px + c_half_w + w_bs >= w_bx);

            // Above the gap top (BirdY < PipeY-GAP+BirdS) or below its bottom
            assign w_outside_gap = (w_by + c_gap_half < w_py + w_bs) ||
                                   (w_by + w_bs > w_py + c_gap_half);

            assign w_pipe_hit[gi] = w_overlap && w_outside_gap;

            // Pipe's right edge clear of the bird's left edge
            assign w_pass_set = (w_px + c_half_w + w_bs < w_bx);
            // Pipe centre right of the bird again (also catches respawn)
            assign w_pass_clr = (w_px > w_bx);

            assign w_pass_new[gi]    = w_pass_set && !r_passed[gi];
            assign w_passed_next[gi] = w_pass_set || (r_passed[gi] && !w_pass_clr);
        end
    endgenerate

    assign w_ground_hit  = (w_by + w_bs >= c_ground_y);
    assign w_ceiling_hit = (w_by < w_bs);
    assign w_hit         = (|w_pipe_hit) || w_ground_hit || w_ceiling_hit;

    // A hit in the same frame as a pass wins, so both the registered and
    // the current-frame hit block the increment.
    assign w_score_inc   = (|w_pass_new) && (r_state == S_PLAY) && !r_hit_q && !w_hit;
    assign w_score_clear = (w_state_next == S_IDLE);

    // ------------------------------------------------------------------
    // Next-state, death counter and registered-output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next     = r_state;
        w_death_cnt_next = '0;
        case (r_state)
            S_IDLE: begin
                if (w_flap_press) begin
                    w_state_next = S_PLAY;
                end
            end
            S_PLAY: begin
                if (r_hit_q) begin
                    w_state_next = S_DYING;
                end
            end
            S_DYING: begin
                if (r_death_cnt == c_death_last) begin
                    w_state_next = S_OVER;
                end else begin
                    w_death_cnt_next = r_death_cnt + 1'b1;
                end
            end
            S_OVER: begin
                if (w_start_press) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        w_run_pipes_next = (w_state_next == S_PLAY);
        w_run_bird_next  = (w_state_next == S_PLAY) || (w_state_next == S_DYING);
        w_game_over_next = (w_state_next == S_OVER);
        w_flap_next      = w_flap_press && ((r_state == S_IDLE) || (r_state == S_PLAY));
    end

    // ------------------------------------------------------------------
    // State, tracking flags and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge frame_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state     <= S_IDLE;
            r_death_cnt <= '0;
            r_key_prev  <= 8'd0;
            r_hit_q     <= 1'b0;
            r_passed    <= '0;
            r_run_pipes <= 1'b0;
            r_run_bird  <= 1'b0;
            r_game_over <= 1'b0;
            r_flap      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_death_cnt <= w_death_cnt_next;
            r_key_prev  <= keycode;
            r_hit_q     <= w_hit;
            r_passed    <= w_passed_next;
            r_run_pipes <= w_run_pipes_next;
            r_run_bird  <= w_run_bird_next;
            r_game_over <= w_game_over_next;
            r_flap      <= w_flap_next;
        end
    end

    bcd_score_counter u_score (
        .frame_clk (frame_clk),
        .Reset_n   (Reset_n),
        .clear     (w_score_clear),
        .inc       (w_score_inc),
        .tens      (score_tens),
        .ones      (score_ones)
    );

    assign game_state = r_state;
    assign run_pipes  = r_run_pipes;
    assign run_bird   = r_run_bird;
    assign game_over  = r_game_over;
    assign flap       = r_flap;

endmodule : flappy_game_ctrl
`default_nettype wire
